// File: rtl/m_axis_rc_adapt_xn_if.sv
// AXI-Stream bundle used on both sides of the RC adapter.
// The widths are parameters, so one definition covers the descriptor side
// (narrow keep, wide tuser, 4-bit ready) and the legacy side.
interface m_axis_rc_adapt_xn_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int KEEP_WIDTH  = 8,
  parameter int USER_WIDTH  = 85,
  parameter int READY_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]  tdata;
  logic [KEEP_WIDTH-1:0]  tkeep;
  logic                   tlast;
  logic [USER_WIDTH-1:0]  tuser;
  logic                   tvalid;
  logic [READY_WIDTH-1:0] tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/m_axis_rc_adapt_xn.sv
// RC completion adapter: turns UltraScale RC descriptor beats into legacy
// 3DW completion-header beats. It has a 2-entry registered skid stage,
// optional dropping of poisoned packets, SOF/EOF sideband, and saturating
// statistics counters.
module m_axis_rc_adapt_xn #(
  parameter int DATA_WIDTH    = 256,
  parameter int KEEP_WIDTH    = DATA_WIDTH/8,
  parameter int USER_IN_WIDTH = 85,
  parameter int DISC_BIT      = 42,
  parameter int DROP_POISONED = 0,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  user_clk,
  input  logic                  user_reset_n,
  m_axis_rc_adapt_xn_if.slave   rc_a,
  m_axis_rc_adapt_xn_if.master  rc,
  input  logic                  stat_clear,
  output logic [CNT_WIDTH-1:0]  stat_pkt,
  output logic [CNT_WIDTH-1:0]  stat_poison,
  output logic [CNT_WIDTH-1:0]  stat_disc
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [3:0]            user;   // {eof, sof, poisoned, discontinue}
  } beat_t;

  typedef enum logic [1:0] {ST_SOP, ST_BODY, ST_DROP} state_t;

  state_t     state_q, state_d;
  beat_t      mem_q [2];
  beat_t      wbeat;
  logic       rd_ptr_q, wr_ptr_q;
  logic [1:0] cnt_q, cnt_d;
  logic       rdy_q, poison_q;
  logic       accept, is_sop, ep, disc, drop_sop, wr_en, rd_en;
  logic       unused_ok;

  assign accept   = rc_a.tvalid & rdy_q;
  assign is_sop   = (state_q == ST_SOP);
  assign ep       = rc_a.tdata[46];
  assign disc     = rc_a.tuser[DISC_BIT];
  assign drop_sop = (DROP_POISONED != 0) && ep;
  // Beats of a packet being dropped are consumed but never stored.
  assign wr_en    = accept & (state_q != ST_DROP) & ~(is_sop & drop_sop);
  assign rd_en    = rc.tvalid & rc.tready[0];

  // The descriptor tkeep is dword-granular and carries nothing the legacy side needs.
  assign unused_ok = ^{rc_a.tkeep, rc_a.tuser};

  // Per-packet state: decide at the first beat whether to forward or drop.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        ST_SOP:  state_d = rc_a.tlast ? ST_SOP : (drop_sop ? ST_DROP : ST_BODY);
        default: if (rc_a.tlast) state_d = ST_SOP;
      endcase
    end
  end

  // Build the beat to store. The SOP beat gets its first 128 bits rewritten to a 3DW header.
  always_comb begin
    logic [11:0] bytecnt;
    logic [7:0]  fmt_type;
    bytecnt  = rc_a.tdata[27:16];
    fmt_type = {(bytecnt != 12'd0) ? 7'b010_0101 : 7'b000_0101, rc_a.tdata[29]};
    wbeat.data = rc_a.tdata;
    wbeat.keep = rc_a.tuser[KEEP_WIDTH-1:0];
    wbeat.last = rc_a.tlast;
    wbeat.user = {rc_a.tlast, is_sop, is_sop ? ep : poison_q, disc};
    if (is_sop) begin
      wbeat.data[63:0]   = {rc_a.tdata[87:72], rc_a.tdata[45:43], 1'b0, bytecnt,
                            fmt_type, 1'b0, rc_a.tdata[91:89], 4'b0, 2'b0,
                            rc_a.tdata[93:92], 2'b0, rc_a.tdata[41:32]};
      wbeat.data[127:64] = {rc_a.tdata[127:96], rc_a.tdata[63:48], rc_a.tdata[71:64],
                            1'b0, rc_a.tdata[6:0]};
      wbeat.keep         = {rc_a.tuser[KEEP_WIDTH-1:12], 12'hFFF};
    end
  end

  // Occupancy after this cycle. Input ready is registered from it.
  always_comb begin
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state: FSM, skid pointers and occupancy, registered ready, poison latch.
  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      state_q  <= ST_SOP;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      rdy_q    <= 1'b0;
      poison_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= (cnt_d != 2'd2);
      if (wr_en) wr_ptr_q <= ~wr_ptr_q;
      if (rd_en) rd_ptr_q <= ~rd_ptr_q;
      if (accept && is_sop) poison_q <= ep;
    end
  end

  // Skid storage is datapath only. The pointers and count decide what is valid.
  always_ff @(posedge user_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wbeat;
  end

  assign rc_a.tready = {4{rdy_q}};
  assign rc.tvalid   = (cnt_q != 2'd0);
  assign rc.tdata    = mem_q[rd_ptr_q].data;
  assign rc.tkeep    = mem_q[rd_ptr_q].keep;
  assign rc.tlast    = mem_q[rd_ptr_q].last;
  assign rc.tuser    = mem_q[rd_ptr_q].user;

  // Saturating counters. Clear wins over a same-cycle increment.
  always_ff @(posedge user_clk) begin
    if (!user_reset_n || stat_clear) begin
      stat_pkt    <= '0;
      stat_poison <= '0;
      stat_disc   <= '0;
    end else begin
      if (rd_en && rc.tlast && stat_pkt != '1)
        stat_pkt <= stat_pkt + CNT_WIDTH'(1);
      if (accept && is_sop && ep && stat_poison != '1)
        stat_poison <= stat_poison + CNT_WIDTH'(1);
      if (accept && rc_a.tlast && disc && stat_disc != '1)
        stat_disc <= stat_disc + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_m_axis_rc_adapt_xn.sv
// Bench for m_axis_rc_adapt_xn. Two instances receive the same stimulus:
// dut0 forwards poisoned packets and has 16-bit counters; dut1 drops
// poisoned packets and has 4-bit counters.
module tb_m_axis_rc_adapt_xn;
  logic         user_clk = 1'b0;
  logic         user_reset_n;
  logic         stat_clear;
  logic [255:0] a_data;
  logic [84:0]  a_user;
  logic         a_last, a_valid, o_rdy;
  logic [15:0]  pkt0, poi0, dsc0;
  logic [3:0]   pkt1, poi1, dsc1;
  int           n_chk = 0, n_err = 0;

  always #5 user_clk = ~user_clk;

  m_axis_rc_adapt_xn_if #(.DATA_WIDTH(256), .KEEP_WIDTH(8),  .USER_WIDTH(85), .READY_WIDTH(4)) in0 ();
  m_axis_rc_adapt_xn_if #(.DATA_WIDTH(256), .KEEP_WIDTH(8),  .USER_WIDTH(85), .READY_WIDTH(4)) in1 ();
  m_axis_rc_adapt_xn_if #(.DATA_WIDTH(256), .KEEP_WIDTH(32), .USER_WIDTH(4),  .READY_WIDTH(1)) out0 ();
  m_axis_rc_adapt_xn_if #(.DATA_WIDTH(256), .KEEP_WIDTH(32), .USER_WIDTH(4),  .READY_WIDTH(1)) out1 ();

  assign in0.tdata = a_data;  assign in1.tdata = a_data;
  assign in0.tkeep = 8'hFF;   assign in1.tkeep = 8'hFF;
  assign in0.tlast = a_last;  assign in1.tlast = a_last;
  assign in0.tuser = a_user;  assign in1.tuser = a_user;
  assign in0.tvalid = a_valid; assign in1.tvalid = a_valid;
  assign out0.tready = o_rdy; assign out1.tready = o_rdy;

  m_axis_rc_adapt_xn #(.DATA_WIDTH(256), .DROP_POISONED(0), .CNT_WIDTH(16)) dut0 (
    .user_clk(user_clk), .user_reset_n(user_reset_n), .rc_a(in0), .rc(out0),
    .stat_clear(stat_clear), .stat_pkt(pkt0), .stat_poison(poi0), .stat_disc(dsc0));
  m_axis_rc_adapt_xn #(.DATA_WIDTH(256), .DROP_POISONED(1), .CNT_WIDTH(4)) dut1 (
    .user_clk(user_clk), .user_reset_n(user_reset_n), .rc_a(in1), .rc(out1),
    .stat_clear(stat_clear), .stat_pkt(pkt1), .stat_poison(poi1), .stat_disc(dsc1));

  typedef struct {
    logic [255:0] d;
    logic [84:0]  u;
    logic         l;
    logic [127:0] e_lo;
    logic [31:0]  e_keep;
    logic         e_last;
    logic [3:0]   e_user;
    logic         e_v1;
  } vec_t;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] mk_hdr(input logic [9:0] dwlen, input logic [11:0] bc,
      input logic [7:0] tag, input logic [15:0] req, input logic [15:0] cpl,
      input logic lk, input logic ep, input logic [2:0] st, input logic [2:0] tc,
      input logic [1:0] attr, input logic [6:0] la);
    logic [255:0] d;
    d = '0;
    d[6:0] = la;     d[27:16] = bc;  d[29] = lk;     d[41:32] = dwlen;
    d[45:43] = st;   d[46] = ep;     d[63:48] = req; d[71:64] = tag;
    d[87:72] = cpl;  d[91:89] = tc;  d[93:92] = attr;
    d[127:96] = 32'hDEADBEEF;
    d[255:128] = 128'h0123456789ABCDEF_FEDCBA9876543210;
    return d;
  endfunction

  task automatic drive(input logic [255:0] d, input logic [84:0] u, input logic l);
    a_data = d; a_user = u; a_last = l; a_valid = 1'b1;
  endtask

  // Streams 8 beats of one packet. The downstream-ready pattern repeats every 4
  // cycles. The bench tracks occupancy to predict input ready.
  task automatic run_stream(input logic [3:0] pat, input int exp_cycles);
    int sent, rcv, occ, c, last_c;
    logic in_acc, out_acc;
    logic [255:0] d;
    sent = 0; rcv = 0; occ = 0; c = 0; last_c = -1;
    d = '0; d[255:224] = 32'd0;
    drive(d, 85'h0_FFFF_FFFF, 1'b0);
    o_rdy = pat[0];
    while (rcv < 8 && c < 200) begin
      @(negedge user_clk);
      in_acc  = a_valid & in0.tready[0];
      out_acc = out0.tvalid & o_rdy;
      chk("stream_ready", in0.tready, (occ < 2) ? 4'hF : 4'h0);
      if (out_acc) begin
        chk("stream_order", out0.tdata[255:224], rcv);
        if (rcv == 7) last_c = c;
        rcv++;
      end
      @(posedge user_clk);
      occ = occ + int'(in_acc) - int'(out_acc);
      if (in_acc) sent++;
      #1;
      c++;
      if (sent < 8) begin
        d = '0; d[255:224] = sent;
        drive(d, 85'h0_FFFF_FFFF, sent == 7);
      end else a_valid = 1'b0;
      o_rdy = pat[c % 4];
    end
    chk("stream_count", rcv, 8);
    if (exp_cycles >= 0) chk("stream_cycles", last_c, exp_cycles);
    a_valid = 1'b0; o_rdy = 1'b1;
    repeat (2) @(posedge user_clk);
    #1;
  endtask

  vec_t vecs [7];

  initial begin
    logic [84:0] u_disc;
    u_disc = '0; u_disc[42] = 1'b1;

    vecs[0] = '{mk_hdr(10'd16, 12'd64, 8'h2A, 16'h0100, 16'h0300, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 7'h00),
                85'h0_F0F0_F000, 1'b0, {64'hDEADBEEF_01002A00, 64'h03000040_4A000010},
                32'hF0F0_FFFF, 1'b0, 4'b0100, 1'b1};
    vecs[1] = '{{8{32'hA5A50001}}, 85'h0_FFFF_FFFF, 1'b0, {4{32'hA5A50001}},
                32'hFFFF_FFFF, 1'b0, 4'b0000, 1'b1};
    vecs[2] = '{{8{32'h3C3C0002}}, 85'h0_0000_FFFF, 1'b1, {4{32'h3C3C0002}},
                32'h0000_FFFF, 1'b1, 4'b1000, 1'b1};
    vecs[3] = '{mk_hdr(10'd0, 12'd0, 8'h05, 16'h0200, 16'h0400, 1'b1, 1'b0, 3'b010, 3'd3, 2'd2, 7'h11),
                85'h0, 1'b1, {64'hDEADBEEF_02000511, 64'h04004000_0B302000},
                32'h0000_0FFF, 1'b1, 4'b1100, 1'b1};
    vecs[4] = '{mk_hdr(10'd2, 12'd8, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b1, 3'd0, 3'd0, 2'd0, 7'h00),
                85'h0_FFFF_FFFF, 1'b0, {64'hDEADBEEF_00000000, 64'h00000008_4A000002},
                32'hFFFF_FFFF, 1'b0, 4'b0110, 1'b0};
    vecs[5] = '{{8{32'h77770005}}, 85'h0_0000_00FF, 1'b1, {4{32'h77770005}},
                32'h0000_00FF, 1'b1, 4'b1010, 1'b0};
    vecs[6] = '{mk_hdr(10'd1, 12'd4, 8'h7F, 16'hABCD, 16'h1234, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 7'h7C),
                u_disc | 85'h0_0000_000F, 1'b1, {64'hDEADBEEF_ABCD7F7C, 64'h12340004_4A000001},
                32'h0000_0FFF, 1'b1, 4'b1101, 1'b1};

    // Reset state
    user_reset_n = 1'b0; stat_clear = 1'b0; a_valid = 1'b0; a_last = 1'b0;
    a_data = '0; a_user = '0; o_rdy = 1'b1;
    repeat (3) @(posedge user_clk);
    #1;
    chk("rst_tvalid", {out0.tvalid, out1.tvalid}, 2'b00);
    chk("rst_ready", {in0.tready, in1.tready}, 8'h00);
    chk("rst_stats", {pkt0, poi0, dsc0, pkt1, poi1, dsc1}, '0);
    user_reset_n = 1'b1;
    @(posedge user_clk); #1;
    chk("rel_ready", {in0.tready, in1.tready}, 8'hFF);

    // Table: each beat appears on the output one cycle after it is accepted
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].d, vecs[i].u, vecs[i].l);
      @(posedge user_clk); #1;
      chk($sformatf("vec%0d_out", i),
          {out0.tvalid, out0.tdata, out0.tkeep, out0.tlast, out0.tuser},
          {1'b1, vecs[i].d[255:128], vecs[i].e_lo, vecs[i].e_keep, vecs[i].e_last, vecs[i].e_user});
      chk($sformatf("vec%0d_drop", i), {out1.tvalid, in1.tready},
          {vecs[i].e_v1, 4'hF});
    end
    a_valid = 1'b0;
    @(posedge user_clk); #1;
    chk("stats0", {pkt0, poi0, dsc0}, {16'd4, 16'd1, 16'd1});
    chk("stats1", {pkt1, poi1, dsc1}, {4'd3, 4'd1, 4'd1});

    // Throughput and backpressure
    run_stream(4'b1111, 8);
    run_stream(4'b1001, -1);

    // Reset asserted during beat 2 of a 4-beat packet
    drive(mk_hdr(10'd8, 12'd32, 8'h01, 16'h0100, 16'h0300, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 7'h00),
          85'h0_FFFF_FFFF, 1'b0);
    @(posedge user_clk); #1;
    drive({8{32'h11112222}}, 85'h0_FFFF_FFFF, 1'b0);
    @(posedge user_clk); #1;
    drive({8{32'h33334444}}, 85'h0_FFFF_FFFF, 1'b0);
    user_reset_n = 1'b0;
    @(posedge user_clk); #1;
    chk("midrst_tvalid", {out0.tvalid, out1.tvalid}, 2'b00);
    chk("midrst_ready", {in0.tready, in1.tready}, 8'h00);
    chk("midrst_stats", {pkt0, poi0, dsc0, pkt1, poi1, dsc1}, '0);
    a_valid = 1'b0; user_reset_n = 1'b1;
    @(posedge user_clk); #1;
    chk("midrst_rel_ready", in0.tready, 4'hF);
    drive(mk_hdr(10'd1, 12'd4, 8'h09, 16'h0100, 16'h0300, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 7'h00),
          85'h0_FFFF_FFFF, 1'b1);
    @(posedge user_clk); #1;
    chk("midrst_sop", {out0.tvalid, out0.tuser, out0.tdata[31:24]}, {1'b1, 4'b1100, 8'h4A});
    a_valid = 1'b0;
    @(posedge user_clk); #1;

    // Saturation: 17 single-beat packets that end with discontinue
    for (int i = 0; i < 17; i++) begin
      drive(mk_hdr(10'd1, 12'd4, 8'(i), 16'h0100, 16'h0300, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 7'h00),
            u_disc | 85'h0_FFFF_FFFF, 1'b1);
      @(posedge user_clk); #1;
    end
    a_valid = 1'b0;
    @(posedge user_clk); #1;
    chk("sat_disc", {dsc0, dsc1}, {16'd17, 4'd15});
    chk("sat_pkt", {pkt0, pkt1}, {16'd18, 4'd15});

    // Clear in the same cycle as an increment
    drive(mk_hdr(10'd1, 12'd4, 8'h55, 16'h0100, 16'h0300, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 7'h00),
          u_disc | 85'h0_FFFF_FFFF, 1'b1);
    stat_clear = 1'b1;
    @(posedge user_clk); #1;
    chk("clear_prio", {pkt0, dsc0, pkt1, dsc1}, '0);
    stat_clear = 1'b0; a_valid = 1'b0;
    @(posedge user_clk); #1;
    chk("post_clear", {pkt0, dsc0, pkt1, dsc1}, {16'd1, 16'd0, 4'd1, 4'd0});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
